inst_cache: RTL
===============

Name: inst_cache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the core's fetch stage and the instruction memory.
- Serves hits from local storage with a fixed latency.
- On a miss, issues a single-word request/valid transaction to instruction memory, fills the line and forwards the word.
- Supports a full invalidate (flush) on fence/branch-redirect events.

Parameters:
- ADDR_WIDTH, 32, fetch and memory address width.
- DATA_WIDTH, 32, instruction word width.
- INDEX_BITS, 6, line index width (2^INDEX_BITS lines; default 64).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- if_req_i  in  1  fetch request; held with if_addr_i until if_ready_o pulses
- if_addr_i  in  ADDR_WIDTH  fetch address (bits [1:0] ignored)
- if_ready_o  out  1  one-cycle pulse: if_inst_o valid for current request
- if_inst_o  out  DATA_WIDTH  returned instruction
- flush_i  in  1  invalidate all lines; abandons in-flight fill
- mem_req_o  out  1  memory read request, held until mem_valid_i
- mem_addr_o  out  ADDR_WIDTH  word-aligned miss address ([1:0]=0)
- mem_valid_i  in  1  memory data valid (single-cycle pulse per request)
- mem_data_i  in  DATA_WIDTH  memory read data

Behaviour:
- Reset (async, rst=1):
  - All valid bits cleared.
  - State=IDLE, drop flag=0.
  - if_ready_o=0, if_inst_o=0, mem_req_o=0, mem_addr_o=0.
  - Takes effect immediately, including mid-miss; an outstanding memory response after reset is ignored.
- Address split: index=addr[INDEX_BITS+1:2]; tag=addr[ADDR_WIDTH-1:INDEX_BITS+2].
- All outputs are registered.
- State IDLE:
  - A request is accepted when if_req_i=1 & if_ready_o=0 & flush_i=0.
  - Hit (valid[index] & tag match): next edge if_ready_o=1, if_inst_o=data[index]; stay IDLE. Hit latency = 1 cycle.
  - Miss: next edge mem_req_o=1, mem_addr_o={addr[ADDR_WIDTH-1:2],2'b00}; go to MISS.
  - The ready-pulse cycle never re-accepts, because the core still drives the old address. Back-to-back hits therefore give one instruction per 2 cycles.
- State MISS:
  - mem_req_o and mem_addr_o held stable.
  - On mem_valid_i & !drop: write line (valid=1, tag, data=mem_data_i); if_ready_o=1; if_inst_o=mem_data_i; mem_req_o=0; go to IDLE.
  - On mem_valid_i & drop: no line write, no ready pulse; mem_req_o=0; drop=0; go to IDLE.
  - Miss latency = memory latency + 1 cycle (ready the edge after mem_valid_i).
- Flush:
  - flush_i=1 clears all valid bits at the next edge.
  - In IDLE, flush has priority over a same-cycle request; that request is not accepted.
  - In MISS, flush sets drop=1 (the memory transaction still completes).
  - flush_i coincident with mem_valid_i: the fill is discarded, no ready pulse, all valids cleared.
- if_ready_o is never high for two consecutive cycles.
- mem_valid_i in IDLE is ignored.
- Line replacement: an unconditional overwrite of the indexed line.

Optional Feature:
- Macro: INST_CACHE_STAT_EN.
- Defined:
  - Adds outputs hit_cnt_o [31:0] and miss_cnt_o [31:0].
  - hit_cnt_o increments on each accepted hit; miss_cnt_o increments on each accepted miss (counted on entry to MISS).
  - Both wrap at 2^32 and reset to 0.
  - Flush does not clear the counters.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared defines file: InstAddrBus, InstBus, ICacheIndexBits, ICacheTagBus, and state encodings ICacheIdle=1'b0, ICacheMiss=1'b1.
- One sub-module: icache_store.
  - Holds the valid vector, tag array and data array.
  - Combinational read port (index -> valid, tag, data).
  - Synchronous write port (we, index, tag, data).
  - Synchronous clear-all input; async reset clears valids.
- FSM, drop flag and stat counters live in inst_cache.

Test Plan:
- Cold miss: reset, if_req_i=1, if_addr_i=0x0000_0010, memory returns 0x0010_0093 after 3 cycles -> mem_req_o=1 with mem_addr_o=0x10 until mem_valid_i; if_ready_o single pulse with if_inst_o=0x0010_0093 the edge after mem_valid_i.
- Hit: re-request 0x10 -> if_ready_o pulse exactly 1 cycle after acceptance, if_inst_o=0x0010_0093, mem_req_o stays 0.
- Conflict: fetch 0x10, then 0x110 (same index, different tag) -> second is a miss that overwrites the line; refetching 0x10 then misses again.
- Flush mid-miss: miss on 0x20, assert flush_i one cycle before mem_valid_i -> no if_ready_o, line not filled; a new request to 0x20 misses again.
- Reset mid-miss: rst pulse while mem_req_o=1 -> mem_req_o and if_ready_o go 0 immediately; late mem_valid_i is ignored; all prior hits become misses.
- Stats (INST_CACHE_STAT_EN): 2 misses + 3 hits -> miss_cnt_o=2, hit_cnt_o=3; flush leaves both unchanged.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
// Optional statistics counters are enabled by defining INST_CACHE_STAT_EN.
package inst_cache_pkg;

  localparam int unsigned InstAddrWidth   = 32;
  localparam int unsigned InstDataWidth   = 32;
  localparam int unsigned ICacheIndexBits = 6;
  localparam int unsigned ICacheTagWidth  = InstAddrWidth - ICacheIndexBits - 2;
  localparam int unsigned StatWidth       = 32;

  typedef logic [InstAddrWidth-1:0]  InstAddrBus;
  typedef logic [InstDataWidth-1:0]  InstBus;
  typedef logic [ICacheTagWidth-1:0] ICacheTagBus;

  typedef enum logic {
    ICacheIdle = 1'b0,
    ICacheMiss = 1'b1
  } icache_state_e;

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// Counter outputs exist only when INST_CACHE_STAT_EN is defined.
interface inst_cache_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_ready_o;
  logic [DATA_WIDTH-1:0] if_inst_o;
  logic                  flush_i;
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_valid_i;
  logic [DATA_WIDTH-1:0] mem_data_i;
`ifdef INST_CACHE_STAT_EN
  logic [31:0]           hit_cnt_o;
  logic [31:0]           miss_cnt_o;
`endif

  modport master (
    output if_req_i, if_addr_i, flush_i, mem_valid_i, mem_data_i,
`ifdef INST_CACHE_STAT_EN
    input  hit_cnt_o, miss_cnt_o,
`endif
    input  if_ready_o, if_inst_o, mem_req_o, mem_addr_o
  );

  modport slave (
    input  if_req_i, if_addr_i, flush_i, mem_valid_i, mem_data_i,
`ifdef INST_CACHE_STAT_EN
    output hit_cnt_o, miss_cnt_o,
`endif
    output if_ready_o, if_inst_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/icache_store.sv
// Line storage for the instruction cache: valid vector, tag and data arrays.
// Combinational read port, synchronous write and clear-all.
module icache_store #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_WIDTH  = 24,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_WIDTH-1:0]  wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid_c,
  output logic [TAG_WIDTH-1:0]  rd_tag_c,
  output logic [DATA_WIDTH-1:0] rd_data_c
);
  localparam int unsigned Lines = 2 ** INDEX_BITS;

  logic [Lines-1:0]      valid;
  logic [TAG_WIDTH-1:0]  tags  [Lines];
  logic [DATA_WIDTH-1:0] datas [Lines];

  // Clear takes priority over a same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_index]  <= wr_tag;
      datas[wr_index] <= wr_data;
    end
  end

  assign rd_valid_c = valid[rd_index];
  assign rd_tag_c   = tags[rd_index];
  assign rd_data_c  = datas[rd_index];
endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache with flush and miss fill.
// Define INST_CACHE_STAT_EN to add hit/miss counters.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = InstAddrWidth,
  parameter int unsigned DATA_WIDTH = InstDataWidth,
  parameter int unsigned INDEX_BITS = ICacheIndexBits
) (
  input logic         clk,
  input logic         rst,
  inst_cache_if.slave bus
);
  localparam int unsigned TagWidth = ADDR_WIDTH - INDEX_BITS - 2;

  icache_state_e         state;
  logic                  drop;
  logic [INDEX_BITS-1:0] req_index;
  logic [TagWidth-1:0]   req_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TagWidth-1:0]   fill_tag;
  logic                  rd_valid_c;
  logic [TagWidth-1:0]   rd_tag_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  hit_c;
  logic                  accept_c;
  logic                  fill_we_c;
  logic                  unused_addr_bits;

  assign req_index  = bus.if_addr_i[INDEX_BITS+1:2];
  assign req_tag    = bus.if_addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign fill_index = bus.mem_addr_o[INDEX_BITS+1:2];
  assign fill_tag   = bus.mem_addr_o[ADDR_WIDTH-1:INDEX_BITS+2];
  assign unused_addr_bits = ^{bus.if_addr_i[1:0], bus.mem_addr_o[1:0]};

  // The ready cycle still carries the old address, so it must not re-accept.
  assign accept_c  = bus.if_req_i && !bus.if_ready_o && !bus.flush_i;
  assign hit_c     = rd_valid_c && (rd_tag_c == req_tag);
  assign fill_we_c = (state == ICacheMiss) && bus.mem_valid_i && !drop && !bus.flush_i;

  icache_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_WIDTH  (TagWidth),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .clear      (bus.flush_i),
    .we         (fill_we_c),
    .wr_index   (fill_index),
    .wr_tag     (fill_tag),
    .wr_data    (bus.mem_data_i),
    .rd_index   (req_index),
    .rd_valid_c (rd_valid_c),
    .rd_tag_c   (rd_tag_c),
    .rd_data_c  (rd_data_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ICacheIdle;
      drop           <= 1'b0;
      bus.if_ready_o <= 1'b0;
      bus.if_inst_o  <= '0;
      bus.mem_req_o  <= 1'b0;
      bus.mem_addr_o <= '0;
`ifdef INST_CACHE_STAT_EN
      bus.hit_cnt_o  <= '0;
      bus.miss_cnt_o <= '0;
`endif
    end else begin
      bus.if_ready_o <= 1'b0;
      case (state)
        ICacheIdle: begin
          if (accept_c) begin
            if (hit_c) begin
              bus.if_ready_o <= 1'b1;
              bus.if_inst_o  <= rd_data_c;
`ifdef INST_CACHE_STAT_EN
              bus.hit_cnt_o  <= bus.hit_cnt_o + 32'd1;
`endif
            end else begin
              bus.mem_req_o  <= 1'b1;
              bus.mem_addr_o <= {bus.if_addr_i[ADDR_WIDTH-1:2], 2'b00};
              state          <= ICacheMiss;
`ifdef INST_CACHE_STAT_EN
              bus.miss_cnt_o <= bus.miss_cnt_o + 32'd1;
`endif
            end
          end
        end
        ICacheMiss: begin
          // A flushed fill still has to drain its memory response.
          if (bus.mem_valid_i) begin
            bus.mem_req_o <= 1'b0;
            drop          <= 1'b0;
            state         <= ICacheIdle;
            if (!drop && !bus.flush_i) begin
              bus.if_ready_o <= 1'b1;
              bus.if_inst_o  <= bus.mem_data_i;
            end
          end else if (bus.flush_i) begin
            drop <= 1'b1;
          end
        end
        default: state <= ICacheIdle;
      endcase
    end
  end
endmodule
